// File: rtl/usb_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : usb_tx_arbiter_if
// Description : Bundle of AXI-Stream requester inputs, the single AXI-Stream
//               output toward the FT60x 245-FIFO driver, and the arbiter's
//               status outputs.
//   Ports (signals):
//     s_axis_tdata/tkeep/tlast/tvalid  per-channel requester beats
//     s_axis_tready                    per-channel ready (arbiter driven)
//     m_axis_tdata/tkeep/tstrb/tlast/tvalid  forwarded beat (arbiter driven)
//     m_axis_tready                    driver ready
//     grant_id, busy                   arbiter status
//   Modports:
//     master : environment view (requesters + driver)
//     slave  : arbiter view
// Revision    : 1.0 - initial release
// ============================================================================
interface usb_tx_arbiter_if #(
    parameter int TDATA_WIDTH = 32,
    parameter int NUM_CH      = 4
);
    localparam int KEEP_W = TDATA_WIDTH / 8;
    localparam int ID_W   = $clog2(NUM_CH);

    logic [NUM_CH*TDATA_WIDTH-1:0] s_axis_tdata;
    logic [NUM_CH*KEEP_W-1:0]      s_axis_tkeep;
    logic [NUM_CH-1:0]             s_axis_tlast;
    logic [NUM_CH-1:0]             s_axis_tvalid;
    logic [NUM_CH-1:0]             s_axis_tready;

    logic [TDATA_WIDTH-1:0]        m_axis_tdata;
    logic [KEEP_W-1:0]             m_axis_tkeep;
    logic [KEEP_W-1:0]             m_axis_tstrb;
    logic                          m_axis_tlast;
    logic                          m_axis_tvalid;
    logic                          m_axis_tready;

    logic [ID_W-1:0]               grant_id;
    logic                          busy;

    modport master (
        output s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tvalid,
        output m_axis_tready,
        input  s_axis_tready,
        input  m_axis_tdata, m_axis_tkeep, m_axis_tstrb, m_axis_tlast, m_axis_tvalid,
        input  grant_id, busy
    );

    modport slave (
        input  s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tvalid,
        input  m_axis_tready,
        output s_axis_tready,
        output m_axis_tdata, m_axis_tkeep, m_axis_tstrb, m_axis_tlast, m_axis_tvalid,
        output grant_id, busy
    );
endinterface
`default_nettype wire

// File: rtl/usb_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : usb_tx_arbiter
// Description : Round-robin, packet-atomic arbiter sharing the FT60x driver's
//               single TX AXI-Stream input among NUM_CH requesters. A grant
//               forwards beats until source tlast or MAX_BEATS beats (forced
//               tlast). Output stage is a registered AXI-Stream slice.
//   Ports:
//     usb_clk     FT60x clock
//     rst_usbclk  asynchronous active-high reset
//     bus         usb_tx_arbiter_if.slave (requesters, driver side, status)
//   Optional feature macro: USB_TX_ARB_HDR_EN
//     When defined, every grant emits one header beat
//     {8'hA5, zeros, grant_id} (tkeep all ones, tlast 0) before its data.
// Revision    : 1.0 - initial release
// ============================================================================
module usb_tx_arbiter #(
    parameter int TDATA_WIDTH = 32,
    parameter int NUM_CH      = 4,
    parameter int MAX_BEATS   = 256
) (
    input  wire logic       usb_clk,
    input  wire logic       rst_usbclk,
    usb_tx_arbiter_if.slave bus
);
    localparam int KEEP_W = TDATA_WIDTH / 8;
    localparam int ID_W   = $clog2(NUM_CH);
    localparam int CNT_W  = $clog2(MAX_BEATS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BEATS - 1);
    localparam logic [ID_W-1:0]  RR_INIT  = ID_W'(NUM_CH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1
`ifdef USB_TX_ARB_HDR_EN
        ,
        S_HDR  = 2'd2
`endif
    } state_t;

    state_t                 state_q;
    logic [ID_W-1:0]        rr_ptr_q;
    logic [ID_W-1:0]        grant_q;
    logic [CNT_W-1:0]       beat_cnt_q;
    logic [TDATA_WIDTH-1:0] m_tdata_q;
    logic [KEEP_W-1:0]      m_tkeep_q;
    logic                   m_tlast_q;
    logic                   m_tvalid_q;

    logic                   load_ok;
    logic                   pick_found;
    logic [ID_W-1:0]        grant_d;
    logic [TDATA_WIDTH-1:0] sel_data;
    logic [KEEP_W-1:0]      sel_keep;
    logic                   sel_last;
    logic                   sel_valid;
    logic                   accept;
    logic                   cap_hit;

    // The output slice can take a new beat when empty or draining this cycle.
    assign load_ok = !m_tvalid_q || bus.m_axis_tready;

    // First valid channel after rr_ptr, wrapping; the last winner is searched last.
    always_comb begin
        pick_found = 1'b0;
        grant_d    = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            if (!pick_found && bus.s_axis_tvalid[(int'(rr_ptr_q) + k) % NUM_CH]) begin
                pick_found = 1'b1;
                grant_d    = ID_W'((int'(rr_ptr_q) + k) % NUM_CH);
            end
        end
    end

    assign sel_data  = bus.s_axis_tdata[grant_q*TDATA_WIDTH +: TDATA_WIDTH];
    assign sel_keep  = bus.s_axis_tkeep[grant_q*KEEP_W +: KEEP_W];
    assign sel_last  = bus.s_axis_tlast[grant_q];
    assign sel_valid = bus.s_axis_tvalid[grant_q];
    assign accept    = (state_q == S_XFER) && sel_valid && load_ok;
    // Compared before increment, so beat_cnt never has to hold MAX_BEATS.
    assign cap_hit   = (beat_cnt_q == CNT_LAST);

    // Only the granted channel sees ready, and only while the slice can load.
    always_comb begin
        bus.s_axis_tready = '0;
        if (state_q == S_XFER) begin
            bus.s_axis_tready[grant_q] = load_ok;
        end
    end

`ifdef USB_TX_ARB_HDR_EN
    logic [TDATA_WIDTH-1:0] hdr_data;
    logic                   hdr_load;

    always_comb begin
        hdr_data                      = '0;
        hdr_data[TDATA_WIDTH-1 -: 8]  = 8'hA5;
        hdr_data[ID_W-1:0]            = grant_q;
    end

    assign hdr_load = (state_q == S_HDR) && load_ok;
`endif

    always_ff @(posedge usb_clk or posedge rst_usbclk) begin
        if (rst_usbclk) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= RR_INIT;
            grant_q    <= '0;
            beat_cnt_q <= '0;
            m_tdata_q  <= '0;
            m_tkeep_q  <= '0;
            m_tlast_q  <= 1'b0;
            m_tvalid_q <= 1'b0;
        end else begin
            // Output slice: load a source (or header) beat, else drain.
            if (accept) begin
                m_tdata_q  <= sel_data;
                m_tkeep_q  <= sel_keep;
                m_tlast_q  <= sel_last || cap_hit;
                m_tvalid_q <= 1'b1;
            end
`ifdef USB_TX_ARB_HDR_EN
            else if (hdr_load) begin
                m_tdata_q  <= hdr_data;
                m_tkeep_q  <= '1;
                m_tlast_q  <= 1'b0;
                m_tvalid_q <= 1'b1;
            end
`endif
            else if (bus.m_axis_tready) begin
                m_tvalid_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    // Arbitration may overlap the last beat still in the slice.
                    if (pick_found) begin
                        grant_q    <= grant_d;
                        rr_ptr_q   <= grant_d;
                        beat_cnt_q <= '0;
`ifdef USB_TX_ARB_HDR_EN
                        state_q    <= S_HDR;
`else
                        state_q    <= S_XFER;
`endif
                    end
                end
`ifdef USB_TX_ARB_HDR_EN
                S_HDR: begin
                    if (load_ok) begin
                        state_q <= S_XFER;
                    end
                end
`endif
                S_XFER: begin
                    // A stalled source keeps the grant indefinitely.
                    if (accept) begin
                        beat_cnt_q <= beat_cnt_q + 1'b1;
                        if (sel_last || cap_hit) begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.m_axis_tdata  = m_tdata_q;
    assign bus.m_axis_tkeep  = m_tkeep_q;
    assign bus.m_axis_tstrb  = m_tkeep_q;
    assign bus.m_axis_tlast  = m_tlast_q;
    assign bus.m_axis_tvalid = m_tvalid_q;
    assign bus.grant_id      = grant_q;
    assign bus.busy          = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_usb_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_usb_tx_arbiter
// Description : Self-checking bench for usb_tx_arbiter. Per-channel packet
//               queues feed the requesters; a packet-level round-robin model
//               turns those queues into the expected output beat list.
//               Honours USB_TX_ARB_HDR_EN for the header beat.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_usb_tx_arbiter;
    localparam int W    = 32;
    localparam int NCH  = 4;
    localparam int MAXB = 4;
    localparam int KW   = W / 8;
    localparam int IDW  = $clog2(NCH);

    typedef struct packed {
        logic          last;
        logic [KW-1:0] keep;
        logic [W-1:0]  data;
    } beat_t;

    typedef struct packed {
        logic [IDW-1:0] ch;
        logic           last;
        logic [KW-1:0]  keep;
        logic [W-1:0]   data;
    } exp_t;

    logic usb_clk    = 1'b0;
    logic rst_usbclk = 1'b1;
    always #5 usb_clk = ~usb_clk;

    usb_tx_arbiter_if #(.TDATA_WIDTH(W), .NUM_CH(NCH)) bus ();

    usb_tx_arbiter #(
        .TDATA_WIDTH(W),
        .NUM_CH     (NCH),
        .MAX_BEATS  (MAXB)
    ) dut (
        .usb_clk   (usb_clk),
        .rst_usbclk(rst_usbclk),
        .bus       (bus)
    );

    beat_t srcq [NCH][$];
    exp_t  expq [$];
    int    checks     = 0;
    int    errors     = 0;
    int    model_rr   = NCH - 1;
    int    rdy_pct    = 100;
    int    gap_pct    = 0;
    int    beats_rx   = 0;
    int    stall_at   = -1;
    int    stall_left = 0;
    logic  prev_stall = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic add_pkt(input int ch, input int len, input logic [W-1:0] base,
                           input logic [W-1:0] step, input bit rnd);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data = rnd ? W'($urandom) : base + step * W'(i);
            b.keep = rnd ? KW'($urandom) : '1;
            b.last = (i == len - 1);
            srcq[ch].push_back(b);
        end
    endtask

    // Packet-level schedule: next non-empty channel after the last winner,
    // forwarding until source tlast or MAXB beats.
    task automatic build_expected();
        int   rd [NCH];
        int   ch;
        int   cnt;
        beat_t b;
        exp_t  e;
        for (int i = 0; i < NCH; i++) rd[i] = 0;
        while (1) begin
            ch = -1;
            for (int k = 1; k <= NCH; k++) begin
                int c;
                c = (model_rr + k) % NCH;
                if (ch < 0 && rd[c] < srcq[c].size()) ch = c;
            end
            if (ch < 0) break;
            model_rr = ch;
`ifdef USB_TX_ARB_HDR_EN
            e.ch   = IDW'(ch);
            e.last = 1'b0;
            e.keep = '1;
            e.data = W'(ch);
            e.data[W-1 -: 8] = 8'hA5;
            expq.push_back(e);
`endif
            cnt = 0;
            do begin
                b = srcq[ch][rd[ch]];
                rd[ch]++;
                cnt++;
                e.ch   = IDW'(ch);
                e.keep = b.keep;
                e.data = b.data;
                e.last = b.last || (cnt == MAXB);
                expq.push_back(e);
            end while (!e.last);
        end
    endtask

    // One clock: entered and left just after the falling edge.
    task automatic cycle();
        logic [NCH*W-1:0]  d;
        logic [NCH*KW-1:0] k;
        logic [NCH-1:0]    l;
        logic [NCH-1:0]    v;
        logic              rdy;
        exp_t              e;
        for (int i = 0; i < NCH; i++) begin
            d[i*W +: W]   = W'($urandom);
            k[i*KW +: KW] = KW'($urandom);
            l[i]          = 1'($urandom);
            v[i]          = 1'b0;
            if (srcq[i].size() > 0 && int'($urandom_range(99)) >= gap_pct) begin
                v[i]          = 1'b1;
                d[i*W +: W]   = srcq[i][0].data;
                k[i*KW +: KW] = srcq[i][0].keep;
                l[i]          = srcq[i][0].last;
            end
        end
        if (stall_left > 0) begin
            rdy = 1'b0;
            stall_left--;
        end else begin
            rdy = (int'($urandom_range(99)) < rdy_pct);
        end
        bus.s_axis_tdata  = d;
        bus.s_axis_tkeep  = k;
        bus.s_axis_tlast  = l;
        bus.s_axis_tvalid = v;
        bus.m_axis_tready = rdy;
        #1;
        if (prev_stall) check("valid_hold", 64'(bus.m_axis_tvalid), 64'(1));
        if (bus.m_axis_tvalid && !bus.m_axis_tready)
            check("tready_backpressure", 64'(bus.s_axis_tready), 64'(0));
        check("tready_onehot", 64'($countones(bus.s_axis_tready) <= 1), 64'(1));
        for (int i = 0; i < NCH; i++) begin
            if (v[i] && bus.s_axis_tready[i]) void'(srcq[i].pop_front());
        end
        if (bus.m_axis_tvalid) begin
            if (expq.size() == 0) begin
                check("unexpected_beat", 64'(1), 64'(0));
            end else begin
                e = expq[0];
                check("tdata", 64'(bus.m_axis_tdata), 64'(e.data));
                check("tkeep", 64'(bus.m_axis_tkeep), 64'(e.keep));
                check("tstrb", 64'(bus.m_axis_tstrb), 64'(e.keep));
                check("tlast", 64'(bus.m_axis_tlast), 64'(e.last));
                if (!e.last) check("grant_id", 64'(bus.grant_id), 64'(e.ch));
            end
            if (bus.m_axis_tready) begin
                beats_rx++;
                if (expq.size() > 0) void'(expq.pop_front());
                if (beats_rx == stall_at) stall_left = 5;
            end
        end
        prev_stall = bus.m_axis_tvalid && !bus.m_axis_tready;
        @(negedge usb_clk);
    endtask

    task automatic run(input string name, input int budget);
        int cyc;
        cyc      = 0;
        beats_rx = 0;
        build_expected();
        while (expq.size() > 0 && cyc < budget) begin
            cycle();
            cyc++;
        end
        check({name, "_complete"}, 64'(expq.size()), 64'(0));
        rdy_pct  = 100;
        stall_at = -1;
        repeat (3) cycle();
        check({name, "_busy_idle"}, 64'(bus.busy), 64'(0));
        check({name, "_tvalid_idle"}, 64'(bus.m_axis_tvalid), 64'(0));
    endtask

    // Entered just after a falling edge; reset asserts mid-cycle.
    task automatic do_reset();
        #2 rst_usbclk = 1'b1;
        #1;
        check("rst_tvalid", 64'(bus.m_axis_tvalid), 64'(0));
        check("rst_tlast", 64'(bus.m_axis_tlast), 64'(0));
        check("rst_tdata", 64'(bus.m_axis_tdata), 64'(0));
        check("rst_tkeep", 64'(bus.m_axis_tkeep), 64'(0));
        check("rst_tready", 64'(bus.s_axis_tready), 64'(0));
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_grant", 64'(bus.grant_id), 64'(0));
        for (int i = 0; i < NCH; i++) srcq[i].delete();
        expq.delete();
        bus.s_axis_tvalid = '0;
        model_rr   = NCH - 1;
        prev_stall = 1'b0;
        stall_left = 0;
        stall_at   = -1;
        @(negedge usb_clk);
        rst_usbclk = 1'b0;
    endtask

    initial begin
        int cyc;
        bus.s_axis_tdata  = '0;
        bus.s_axis_tkeep  = '0;
        bus.s_axis_tlast  = '0;
        bus.s_axis_tvalid = '0;
        bus.m_axis_tready = 1'b0;
        @(negedge usb_clk);
        do_reset();

        // Single channel, three beats.
        rdy_pct = 100;
        add_pkt(2, 3, 32'h11, 32'h11, 1'b0);
        run("single", 100);

        // Round robin from reset: all four channels hold 2-beat packets.
        do_reset();
        for (int c = 0; c < NCH; c++) add_pkt(c, 2, 32'h100 * W'(c + 1), 32'h1, 1'b0);
        run("round_robin", 200);

        // Five-cycle backpressure after the first output beat.
        rdy_pct  = 100;
        stall_at = 1;
        add_pkt(1, 3, 32'hB0, 32'h1, 1'b0);
        run("backpressure", 200);

        // Burst cap with a competing channel.
        do_reset();
        add_pkt(1, 10, 32'hC100, 32'h1, 1'b0);
        add_pkt(3, 3, 32'hC300, 32'h1, 1'b0);
        run("burst_cap", 300);

        // Granted source stalls mid-packet; grant must be kept.
        gap_pct = 40;
        rdy_pct = 60;
        add_pkt(0, 6, 32'hD000, 32'h1, 1'b0);
        run("source_gaps", 500);
        gap_pct = 0;

        // Randomized traffic across all channels.
        for (int r = 0; r < 15; r++) begin
            rdy_pct = 70;
            for (int c = 0; c < NCH; c++) begin
                int np;
                np = int'($urandom_range(3));
                for (int p = 0; p < np; p++) add_pkt(c, int'($urandom_range(9, 1)), '0, '0, 1'b1);
            end
            run("random", 2000);
        end

        // Reset in the middle of a 5-beat packet.
        do_reset();
        rdy_pct  = 100;
        beats_rx = 0;
        add_pkt(2, 5, 32'hE200, 32'h1, 1'b0);
        build_expected();
        cyc = 0;
        while (beats_rx < 1 && cyc < 50) begin
            cycle();
            cyc++;
        end
        check("midreset_started", 64'(beats_rx), 64'(1));
        do_reset();
        add_pkt(3, 2, 32'hF300, 32'h1, 1'b0);
        add_pkt(1, 3, 32'hF100, 32'h1, 1'b0);
        run("after_reset", 200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/usb_tx_arbiter.md
Name: usb_tx_arbiter

Overview:
- Shares the single USB TX AXI-Stream input of the FT60x 245-FIFO driver among NUM_CH independent requester streams.
- Arbitration is round-robin and packet-atomic. A packet forwards uninterrupted until its tlast or a MAX_BEATS burst cap.
- Sits in the usb_clk domain, directly upstream of the FT60x driver's s_axis port.
- Has a registered output stage, so the driver sees clean timing.

Parameters:
- TDATA_WIDTH, 32, beat width in bits (16 or 32, matching FT600/FT601).
- NUM_CH, 4, number of requester channels (2..8).
- MAX_BEATS, 256, maximum beats per grant before a forced tlast (2..4096).

Ports:
- usb_clk  in  1  FT60x clock; everything below is synchronous to it.
- rst_usbclk  in  1  asynchronous, active-high reset.
- s_axis_tdata  in  NUM_CH*TDATA_WIDTH  channel i occupies slice [i*TDATA_WIDTH +: TDATA_WIDTH].
- s_axis_tkeep  in  NUM_CH*TDATA_WIDTH/8  per-channel byte keep.
- s_axis_tlast  in  NUM_CH  per-channel end of packet.
- s_axis_tvalid  in  NUM_CH  per-channel valid.
- s_axis_tready  out  NUM_CH  per-channel ready.
- m_axis_tdata  out  TDATA_WIDTH  to driver s_axis_tdata.
- m_axis_tkeep  out  TDATA_WIDTH/8  to driver tkeep.
- m_axis_tstrb  out  TDATA_WIDTH/8  always equal to m_axis_tkeep.
- m_axis_tlast  out  1  end of forwarded packet.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tready  in  1  driver ready.
- grant_id  out  $clog2(NUM_CH)  currently or last granted channel.
- busy  out  1  high while not in S_IDLE.

Behaviour:
- Reset (async assert, release synchronous to usb_clk):
  - state = S_IDLE, rr_ptr = NUM_CH-1, grant_id = 0, beat_cnt = 0.
  - m_axis_tvalid = 0, m_axis_tlast = 0, m_axis_tdata = 0, m_axis_tkeep = 0.
  - All s_axis_tready = 0, busy = 0.
- Reset mid-packet: the output beat is discarded and the grant is dropped. Upstream restarts the packet; no recovery is attempted.
- Output register:
  - Define load_ok = !m_axis_tvalid || m_axis_tready.
  - On a load, m_axis_* take the selected source values.
  - When m_axis_tready is high and nothing is loaded, m_axis_tvalid clears.
  - Output data is stable while m_axis_tvalid=1 and m_axis_tready=0.
- S_IDLE:
  - All s_axis_tready = 0.
  - If any s_axis_tvalid is high, pick the first valid channel searching rr_ptr+1, rr_ptr+2, ... modulo NUM_CH.
  - Register that channel into grant_id, set rr_ptr = grant, clear beat_cnt, and go to S_XFER (S_HDR when the option is enabled).
  - Arbitration costs exactly one cycle. It may overlap with the final beat still draining from the output register.
- S_XFER:
  - s_axis_tready[grant_id] = load_ok; all other channels' tready = 0.
  - A beat is accepted when s_axis_tvalid[g] and tready[g] are both high. On acceptance:
    - The beat loads into the output register.
    - beat_cnt increments.
    - m_axis_tlast = s_axis_tlast[g] OR (beat_cnt == MAX_BEATS-1).
    - If m_axis_tlast is set, go to S_IDLE.
  - A forced tlast (cap reached without source tlast) splits the packet. The remainder is forwarded under a later grant to the same channel.
  - If the granted source drops tvalid mid-packet, the arbiter waits indefinitely. There is no timeout and the grant is kept.
- Fairness: a channel that just finished is searched last. With all channels continuously valid, the grant order is 0,1,2,3,0,...
- Throughput: one beat per cycle in steady state. The only bubble is one idle cycle between packets on the output whenever the arbitration cycle cannot hide behind output backpressure.
- Simultaneous events: tvalid from other channels during S_XFER is ignored until S_IDLE.
- Width rule: beat_cnt is $clog2(MAX_BEATS) bits wide and must not wrap before the cap compare.

Optional Feature:
- Macro: USB_TX_ARB_HDR_EN.
- Defined:
  - A state S_HDR sits between S_IDLE and S_XFER.
  - When load_ok is high, S_HDR loads one header beat: tdata = {8'hA5 in the top byte, zeros, grant_id in the LSBs}, tkeep all ones, tlast = 0.
  - Then it proceeds to S_XFER.
  - All s_axis_tready stay 0 in S_HDR.
  - The header does not count toward MAX_BEATS.
  - Each grant, including continuations after a forced tlast, produces exactly one header.
- Undefined: S_HDR is not built, and S_IDLE goes directly to S_XFER.

Test Plan:
- Single channel: ch2 sends 3 beats 0x11,0x22,0x33 with tlast on 0x33, m_axis_tready=1. Output is the same 3 beats, tlast on beat 3, grant_id=2, busy then returns to 0.
- Round robin: ch0..ch3 each hold a 2-beat packet valid from cycle 0. Output packet order is 0,1,2,3 with no interleaving of beats.
- Backpressure: mid-packet, m_axis_tready is driven low for 5 cycles. m_axis_tdata/tvalid hold their value, s_axis_tready[g] is 0, and no beats are lost or duplicated.
- Burst cap, MAX_BEATS=4: ch1 sends a 10-beat packet while ch3 is also valid. Output sequence is ch1 beats 1-4 (forced tlast), ch3's packet, ch1 beats 5-8 (forced tlast), ch1 beats 9-10 (source tlast).
- Reset: rst_usbclk pulses during beat 2 of a 5-beat packet. All outputs read their reset values within the same cycle, and after release the next grant goes to the lowest-index valid channel.
- USB_TX_ARB_HDR_EN on: a ch3 packet of 2 beats, TDATA_WIDTH=32, produces 0xA5000003 first (tlast=0), followed by the 2 data beats.
